cic_up37: RTL and testbench

- CIC interpolation filter, the counterpart of the existing CIC decimator in the rate-converter library.
- Upsamples a 16-bit PCM stream by R (default 37) using N comb stages at the input rate and N integrator stages at the output rate.
- Sink and source are Avalon-ST with valid/ready handshakes.
- Sits between a low-rate audio source and the high-rate mixer/DAC path.

---
 rtl/cic_up37.sv | 180 ++++++++++++++++++
 tb/tb_cic_up37.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_up37.sv
// CIC interpolator: N comb stages at the input rate, zero stuffing by R,
// N integrator stages at the output rate, output = integrator >>> GROWTH.
// Latency: accept at edge E, first output valid after edge E+1; R outputs per input.
// Backpressure: out_ready low freezes the integrators and holds the output;
// in_ready stays low until the last of the R outputs has been produced.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   in_data/in_valid/in_ready       Avalon-ST sink (PCM sample)
//   in_error/in_startofpacket/
//   in_endofpacket                  sink sideband, captured per accepted sample
//   out_data/out_valid/out_ready    Avalon-ST source (upsampled PCM)
//   out_error/out_startofpacket/
//   out_endofpacket/out_channel     source sideband (channel is always 0)
module cic_up37 #(
  parameter int IN_W   = 16,
  parameter int R      = 37,
  parameter int N      = 3,
  parameter int GROWTH = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_error,
  input  logic            in_startofpacket,
  input  logic            in_endofpacket,
  output logic [IN_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_error,
  output logic            out_startofpacket,
  output logic            out_endofpacket,
  output logic            out_channel
);

  localparam int ACC_W = IN_W + GROWTH;
  localparam int PH_W  = 8;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

  typedef logic signed [ACC_W-1:0] acc_t;

  // comb differential delays and integrator accumulators
  acc_t d_q [N];
  acc_t d_d [N];
  acc_t i_q [N];
  acc_t i_d [N];
  acc_t c_out_q, c_out_d;

  logic [PH_W-1:0] ph_q, ph_d;
  logic            busy_q, busy_d;
  logic [1:0]      cap_err_q, cap_err_d;
  logic            cap_sop_q, cap_sop_d;
  logic            cap_eop_q, cap_eop_d;

  logic [IN_W-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      out_err_q, out_err_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;

  // combinational stage values: index 0 is the stage input
  acc_t comb_v  [N+1];
  acc_t integ_v [N+1];

  logic accept;
  logic adv;

  assign accept = in_valid & ~busy_q;
  assign adv    = busy_q & (~out_valid_q | out_ready);

  always_comb begin
    comb_v[0] = {{GROWTH{in_data[IN_W-1]}}, in_data};
    for (int k = 1; k <= N; k++) begin
      comb_v[k] = comb_v[k-1] - d_q[k-1];
    end
    // zero stuffing: the comb result enters only on the first phase
    integ_v[0] = (ph_q == '0) ? c_out_q : '0;
    // each integrator sees the freshly updated value of the stage before it
    for (int k = 1; k <= N; k++) begin
      integ_v[k] = i_q[k-1] + integ_v[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      d_d[k] = d_q[k];
      i_d[k] = i_q[k];
    end
    c_out_d     = c_out_q;
    ph_d        = ph_q;
    busy_d      = busy_q;
    cap_err_d   = cap_err_q;
    cap_sop_d   = cap_sop_q;
    cap_eop_d   = cap_eop_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    if (accept) begin
      for (int k = 0; k < N; k++) begin
        d_d[k] = comb_v[k];
      end
      c_out_d   = comb_v[N];
      cap_err_d = in_error;
      cap_sop_d = in_startofpacket;
      cap_eop_d = in_endofpacket;
      busy_d    = 1'b1;
      ph_d      = '0;
    end

    if (adv) begin
      for (int k = 0; k < N; k++) begin
        i_d[k] = integ_v[k+1];
      end
      // top IN_W bits: arithmetic shift right by GROWTH (floor)
      out_data_d  = integ_v[N][ACC_W-1:GROWTH];
      out_valid_d = 1'b1;
      out_err_d   = cap_err_q;
      out_sop_d   = (ph_q == '0) & cap_sop_q;
      out_eop_d   = (ph_q == PH_LAST) & cap_eop_q;
      if (ph_q == PH_LAST) begin
        busy_d = 1'b0;
        ph_d   = '0;
      end else begin
        ph_d = ph_q + 8'd1;
      end
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        d_q[k] <= '0;
        i_q[k] <= '0;
      end
      c_out_q     <= '0;
      ph_q        <= '0;
      busy_q      <= 1'b0;
      cap_err_q   <= '0;
      cap_sop_q   <= 1'b0;
      cap_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        d_q[k] <= d_d[k];
        i_q[k] <= i_d[k];
      end
      c_out_q     <= c_out_d;
      ph_q        <= ph_d;
      busy_q      <= busy_d;
      cap_err_q   <= cap_err_d;
      cap_sop_q   <= cap_sop_d;
      cap_eop_q   <= cap_eop_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign in_ready          = ~busy_q;
  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;
  assign out_error         = out_err_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_channel       = 1'b0;

endmodule

// File: tb/tb_cic_up37.sv
module tb_cic_up37;

  localparam int R = 37;

  logic        clk;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_error;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_error;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic        out_channel;

  cic_up37 dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_error          (in_error),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_error         (out_error),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // captured outputs of the most recent input sample
  int         outs [R];
  logic [1:0] errs [R];
  logic       sops [R];
  logic       eops [R];
  int         n_got;
  int         low_cnt;
  int         first_vld;

  // reference: zero-stuffed input convolved with the boxcar^3 impulse response
  int h [109];
  int x_hist [6];

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int model_y(input int m, input int j);
    int acc;
    int idx;
    acc = 0;
    for (int mm = 0; mm <= m; mm++) begin
      idx = (m - mm) * R + j;
      if (idx < 109) acc += x_hist[mm] * h[idx];
    end
    return acc >>> 11;
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready always 1
  // mode 1: 5-cycle stall when output 4 is presented, then toggling
  // mode 2: reset asserted when output 20 is presented
  task automatic run_sample(input int data, input logic [1:0] err,
                            input logic sop, input logic eop, input int mode);
    int guard;
    int cyc;
    int stall_start;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 0, 1);
    in_data          = data[15:0];
    in_error         = err;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_valid         = 1'b1;
    @(posedge clk);
    #1;
    in_valid         = 1'b0;
    in_data          = '0;
    in_error         = '0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    n_got = 0;
    cyc = 0;
    low_cnt = 0;
    first_vld = -1;
    stall_start = -1;
    while (n_got < R && cyc < 400) begin
      if (!in_ready) low_cnt++;
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (mode == 2 && out_valid && n_got == 20) begin
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        break;
      end
      out_ready = 1'b1;
      if (mode == 1) begin
        if (stall_start < 0 && out_valid && n_got == 4) stall_start = cyc;
        if (stall_start >= 0) begin
          if (cyc < stall_start + 5) begin
            out_ready = 1'b0;
            check("stall_hold", $signed(out_data), 15);
          end else begin
            out_ready = cyc[0];
          end
        end
      end
      if (out_valid && out_ready) begin
        outs[n_got] = $signed(out_data);
        errs[n_got] = out_error;
        sops[n_got] = out_startofpacket;
        eops[n_got] = out_endofpacket;
        n_got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b1;
    if (mode != 2) begin
      check("output_count", n_got, R);
      check("drain_out_valid", out_valid, 0);
      check("drain_in_ready", in_ready, 1);
    end
  endtask

  task automatic dc_run(input int level, input int settled);
    for (int m = 0; m < 6; m++) x_hist[m] = level;
    for (int m = 0; m < 6; m++) begin
      run_sample(level, 2'b00, 1'b0, 1'b0, 0);
      check("dc_first_valid", first_vld, 1);
      check("dc_ready_low", low_cnt, R);
      for (int j = 0; j < R; j++) begin
        check("dc_value", outs[j], (m >= 2) ? settled : model_y(m, j));
      end
    end
  endtask

  initial begin
    int cnt;
    for (int n = 0; n < 109; n++) h[n] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a+b+c] += 1;

    reset_n = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    in_error = '0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    out_ready = 1'b1;

    // reset state (asynchronous, before any clock edge)
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_error", out_error, 0);
    check("rst_sop", out_startofpacket, 0);
    check("rst_eop", out_endofpacket, 0);
    check("rst_channel", out_channel, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
    end

    // DC +1000: settled 1369000 >>> 11 = 668
    dc_run(1000, 668);

    // DC -1000: settled -1369000 >>> 11 = -669 (floor)
    do_reset();
    dc_run(-1000, -669);

    // impulse 2048: output k = (k+1)(k+2)/2
    do_reset();
    run_sample(2048, 2'b00, 1'b0, 1'b0, 0);
    check("imp_first_valid", first_vld, 1);
    check("imp_ready_low", low_cnt, R);
    for (int k = 0; k < R; k++) check("imp_value", outs[k], (k + 1) * (k + 2) / 2);
    check("imp_last", outs[36], 703);

    // impulse under backpressure
    do_reset();
    run_sample(2048, 2'b00, 1'b0, 1'b0, 1);
    for (int k = 0; k < R; k++) check("stall_value", outs[k], (k + 1) * (k + 2) / 2);

    // packet flags and error propagation
    do_reset();
    run_sample(2048, 2'b10, 1'b1, 1'b1, 0);
    check("sop_first", sops[0], 1);
    check("eop_last", eops[36], 1);
    cnt = 0;
    for (int k = 0; k < R; k++) cnt += sops[k];
    check("sop_count", cnt, 1);
    cnt = 0;
    for (int k = 0; k < R; k++) cnt += eops[k];
    check("eop_count", cnt, 1);
    cnt = 0;
    for (int k = 0; k < R; k++) if (errs[k] == 2'b10) cnt++;
    check("err_count", cnt, R);

    // reset mid-burst aborts it; the next DC run starts from clean state
    run_sample(2048, 2'b10, 1'b1, 1'b1, 2);
    do_reset();
    check("post_abort_out_valid", out_valid, 0);
    check("post_abort_in_ready", in_ready, 1);
    dc_run(1000, 668);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
